// File: rtl/lcd_step_pkg.sv
// Shared state encoding, default timing and counter widths for the LCD step controller.
package lcd_step_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STEP     = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_LCD_RST  = 3'd3,
        ST_LCD_WAIT = 3'd4
    } state_e;

    // Defaults assume a 50 MHz board clock.
    localparam int DEB_CYCLES_DEF    = 1000000;
    localparam int RST_CYCLES_DEF    = 4;
    localparam int T_LCD_REFRESH_DEF = 300000;
    localparam int RUN_PERIOD_DEF    = 25000000;

    localparam int DEB_CNT_W = 20;
    localparam int REF_CNT_W = 19;
    localparam int RUN_CNT_W = 25;

endpackage

// File: rtl/lcd_step_ctrl_debounce.sv
// Two-flop synchroniser plus stable-level debouncer for an active-low pushbutton;
// emits a one-cycle pulse when a press (high-to-low) is accepted.
module btn_debounce
    import lcd_step_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic fall_o
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 level_q;
    logic                 fall_q;
    logic [DEB_CNT_W-1:0] cnt_q;

    // Released (high) is the idle level, so the button starts out accepted as released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            fall_q  <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                fall_q  <= ~sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/lcd_step_ctrl.sv
// Steps or free-runs the core, snapshots its output/PC for the LCD writer and
// restarts the LCD write after every step, throttled to the screen refresh time.
module lcd_step_ctrl
    import lcd_step_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int RST_CYCLES    = RST_CYCLES_DEF,
    parameter int T_LCD_REFRESH = T_LCD_REFRESH_DEF,
    parameter int RUN_PERIOD    = RUN_PERIOD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step_n,
    input  logic        sw_run,
    input  logic [31:0] cpu_output,
    input  logic [31:0] cpu_pc,
    output logic        cpu_clk_en,
    output logic [31:0] disp_output,
    output logic [31:0] disp_pc,
    output logic        lcd_rst_n,
    output logic        busy,
    output state_e      state_dbg
);

    localparam logic [REF_CNT_W-1:0] RST_LAST = REF_CNT_W'(RST_CYCLES - 1);
    localparam logic [REF_CNT_W-1:0] REF_LAST = REF_CNT_W'(T_LCD_REFRESH - 1);
    localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(RUN_PERIOD - 1);

    logic                 press;
    logic                 step_req;
    logic                 run_sync1_q;
    logic                 run_sync2_q;
    logic                 run_req_q;
    logic [RUN_CNT_W-1:0] run_cnt_q;

    state_e               state_q;
    logic [REF_CNT_W-1:0] tmr_q;
    logic                 pending_q;
    logic                 clk_en_q;
    logic                 lcd_rst_n_q;
    logic                 busy_q;
    logic [31:0]          disp_out_q;
    logic [31:0]          disp_pc_q;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_n_i (btn_step_n),
        .fall_o  (press)
    );

    // Run-mode request generator; held cleared while in step mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_sync1_q <= 1'b0;
            run_sync2_q <= 1'b0;
            run_req_q   <= 1'b0;
            run_cnt_q   <= '0;
        end else begin
            run_sync1_q <= sw_run;
            run_sync2_q <= run_sync1_q;
            run_req_q   <= 1'b0;
            if (!run_sync2_q) begin
                run_cnt_q <= '0;
            end else if (run_cnt_q == RUN_LAST) begin
                run_cnt_q <= '0;
                run_req_q <= 1'b1;
            end else begin
                run_cnt_q <= run_cnt_q + 1'b1;
            end
        end
    end

    assign step_req = (press & ~run_sync2_q) | run_req_q;

    // Reset lands in CAPTURE so the first screen shows the core's reset-state PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_CAPTURE;
            tmr_q       <= '0;
            pending_q   <= 1'b0;
            clk_en_q    <= 1'b0;
            lcd_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            disp_out_q  <= '0;
            disp_pc_q   <= '0;
        end else begin
            if (busy_q && step_req) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (step_req || pending_q) begin
                        state_q   <= ST_STEP;
                        clk_en_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                ST_STEP: begin
                    state_q  <= ST_CAPTURE;
                    clk_en_q <= 1'b0;
                end
                ST_CAPTURE: begin
                    disp_out_q  <= cpu_output;
                    disp_pc_q   <= cpu_pc;
                    state_q     <= ST_LCD_RST;
                    lcd_rst_n_q <= 1'b0;
                    tmr_q       <= '0;
                end
                ST_LCD_RST: begin
                    if (tmr_q == RST_LAST) begin
                        state_q     <= ST_LCD_WAIT;
                        lcd_rst_n_q <= 1'b1;
                        tmr_q       <= '0;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_LCD_WAIT: begin
                    if (tmr_q == REF_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    clk_en_q    <= 1'b0;
                    lcd_rst_n_q <= 1'b1;
                    tmr_q       <= '0;
                end
            endcase
        end
    end

    assign cpu_clk_en  = clk_en_q;
    assign disp_output = disp_out_q;
    assign disp_pc     = disp_pc_q;
    assign lcd_rst_n   = lcd_rst_n_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_lcd_step_ctrl.sv
// Directed bench for lcd_step_ctrl with scaled timing; a small core model advances
// PC by 4 and output by 0x2A on each enable, and snapshots are scoreboarded.
module tb_lcd_step_ctrl;
    import lcd_step_pkg::*;

    logic        clk;
    logic        rst;
    logic        btn_step_n;
    logic        sw_run;
    logic [31:0] cpu_output;
    logic [31:0] cpu_pc;
    logic        cpu_clk_en;
    logic [31:0] disp_output;
    logic [31:0] disp_pc;
    logic        lcd_rst_n;
    logic        busy;
    state_e      state_dbg;

    int          n_checks;
    int          n_errors;
    int          ncyc;
    int          run_start;
    logic        prev_lcd;
    logic [63:0] exp_q[$];
    int          pulse_q[$];

    lcd_step_ctrl #(
        .DEB_CYCLES    (8),
        .RST_CYCLES    (4),
        .T_LCD_REFRESH (50),
        .RUN_PERIOD    (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_step_n  (btn_step_n),
        .sw_run      (sw_run),
        .cpu_output  (cpu_output),
        .cpu_pc      (cpu_pc),
        .cpu_clk_en  (cpu_clk_en),
        .disp_output (disp_output),
        .disp_pc     (disp_pc),
        .lcd_rst_n   (lcd_rst_n),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int k);
        exp_q.push_back({32'h00400000 + 32'(4 * k), 32'(42 * k)});
    endtask

    task automatic press(input int low_cycles, input int high_cycles);
        btn_step_n = 1'b0;
        repeat (low_cycles) tick();
        btn_step_n = 1'b1;
        repeat (high_cycles) tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Release reset and follow the boot snapshot/restart sequence edge by edge.
    task automatic boot_seq(input string tag);
        @(negedge clk);
        rst = 1'b1;
        pulse_q.delete();
        @(posedge clk); #1;
        chk({tag, "_disp_pc"}, 64'(disp_pc), 64'h00400000);
        chk({tag, "_disp_out"}, 64'(disp_output), 64'd0);
        chk({tag, "_lcd_low_e1"}, 64'(lcd_rst_n), 64'd0);
        chk({tag, "_state_e1"}, 64'(state_dbg), 64'(ST_LCD_RST));
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_lcd_low_e4"}, 64'(lcd_rst_n), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_lcd_high_e5"}, 64'(lcd_rst_n), 64'd1);
        chk({tag, "_state_e5"}, 64'(state_dbg), 64'(ST_LCD_WAIT));
        repeat (49) @(posedge clk);
        #1;
        chk({tag, "_busy_e54"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_busy_e55"}, 64'(busy), 64'd0);
        chk({tag, "_state_e55"}, 64'(state_dbg), 64'(ST_IDLE));
        chk({tag, "_no_enable"}, 64'(pulse_q.size()), 64'd0);
    endtask

    // Core model: registers update one cycle after the enable.
    initial begin
        forever begin
            @(posedge clk);
            if (cpu_clk_en === 1'b1) begin
                #1;
                cpu_pc     = cpu_pc + 32'd4;
                cpu_output = cpu_output + 32'h2A;
            end
        end
    end

    // Enable pulse log and snapshot scoreboard at the end of each restart pulse.
    initial begin
        prev_lcd = 1'b0;
        ncyc     = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (cpu_clk_en === 1'b1) pulse_q.push_back(ncyc);
            if (rst === 1'b1 && lcd_rst_n === 1'b1 && prev_lcd === 1'b0) begin
                if (exp_q.size() == 0) chk("sb_unexpected_snapshot", 64'(exp_q.size()), 64'd1);
                else chk("sb_snapshot", {disp_pc, disp_output}, exp_q.pop_front());
            end
            prev_lcd = lcd_rst_n;
        end
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        btn_step_n = 1'b1;
        sw_run     = 1'b0;
        cpu_pc     = 32'h00400000;
        cpu_output = 32'd0;
        #2 rst = 1'b0;
        tick();
        tick();

        chk("rst_clk_en", 64'(cpu_clk_en), 64'd0);
        chk("rst_disp_out", 64'(disp_output), 64'd0);
        chk("rst_disp_pc", 64'(disp_pc), 64'd0);
        chk("rst_lcd_rst_n", 64'(lcd_rst_n), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_state", 64'(state_dbg), 64'(ST_CAPTURE));

        push_exp(0);
        boot_seq("s1");

        // Clean press: enable 11 cycles after the press, snapshot one cycle after it ends.
        push_exp(1);
        pulse_q.delete();
        tick();
        btn_step_n = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 20) btn_step_n = 1'b1;
            case (t)
                10: chk("s2_en_early", 64'(cpu_clk_en), 64'd0);
                11: chk("s2_en_t11", 64'(cpu_clk_en), 64'd1);
                12: begin
                    chk("s2_en_t12", 64'(cpu_clk_en), 64'd0);
                    chk("s2_disp_hold", 64'(disp_pc), 64'h00400000);
                end
                13: begin
                    chk("s2_disp_pc", 64'(disp_pc), 64'h00400004);
                    chk("s2_disp_out", 64'(disp_output), 64'h2A);
                    chk("s2_lcd_low_t13", 64'(lcd_rst_n), 64'd0);
                end
                16: chk("s2_lcd_low_t16", 64'(lcd_rst_n), 64'd0);
                17: chk("s2_lcd_high_t17", 64'(lcd_rst_n), 64'd1);
                default: ;
            endcase
        end
        wait_idle("s2", 200);
        chk("s2_pulses", 64'(pulse_q.size()), 64'd1);

        // Bouncy press: 5 toggles 3 cycles apart then held low.
        push_exp(2);
        pulse_q.delete();
        tick();
        for (int t = 0; t < 35; t++) begin
            btn_step_n = (t < 15) ? ((t / 3) % 2 == 1) : 1'b0;
            tick();
        end
        btn_step_n = 1'b1;
        wait_idle("s3", 200);
        chk("s3_pulses", 64'(pulse_q.size()), 64'd1);

        // Three presses in one busy window: one served, one pending, one dropped.
        push_exp(3);
        push_exp(4);
        pulse_q.delete();
        tick();
        repeat (3) press(12, 12);
        wait_idle("s4", 300);
        chk("s4_pulses", 64'(pulse_q.size()), 64'd2);
        if (pulse_q.size() == 2) chk("s4_spacing", 64'(pulse_q[1] - pulse_q[0]), 64'd57);

        // Run mode for 1010 cycles with presses that must be ignored.
        for (int k = 5; k < 15; k++) push_exp(k);
        pulse_q.delete();
        tick();
        sw_run    = 1'b1;
        run_start = ncyc;
        for (int t = 1; t <= 1010; t++) begin
            tick();
            btn_step_n = !((t >= 150 && t < 162) || (t >= 420 && t < 432));
        end
        sw_run = 1'b0;
        repeat (150) tick();
        wait_idle("s5", 200);
        chk("s5_pulses", 64'(pulse_q.size()), 64'd10);
        if (pulse_q.size() > 0) chk("s5_first", 64'(pulse_q[0] - run_start), 64'd103);
        for (int i = 1; i < pulse_q.size(); i++) begin
            chk("s5_interval", 64'(pulse_q[i] - pulse_q[i-1]), 64'd100);
        end

        // Reset during LCD_WAIT clears everything at once, then boots as from power-up.
        push_exp(15);
        pulse_q.delete();
        tick();
        press(20, 30);
        chk("s6_pulses", 64'(pulse_q.size()), 64'd1);
        chk("s6_pre_state", 64'(state_dbg), 64'(ST_LCD_WAIT));
        rst = 1'b0;
        #1;
        chk("s6_lcd_rst_n", 64'(lcd_rst_n), 64'd0);
        chk("s6_disp_pc", 64'(disp_pc), 64'd0);
        chk("s6_disp_out", 64'(disp_output), 64'd0);
        chk("s6_busy", 64'(busy), 64'd1);
        chk("s6_clk_en", 64'(cpu_clk_en), 64'd0);
        chk("s6_state", 64'(state_dbg), 64'(ST_CAPTURE));
        cpu_pc     = 32'h00400000;
        cpu_output = 32'd0;
        push_exp(0);
        repeat (3) tick();
        boot_seq("s6");

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
